// File: rtl/mesh_perf_mon_pkg.sv
// Shared definitions for the mesh performance monitor: readout selector
// encodings, readout FSM states and the saturating-maximum helper.
package mesh_perf_mon_pkg;

    // Counter selector values carried on rd_sel
    localparam logic [1:0] SEL_STALL = 2'd0;
    localparam logic [1:0] SEL_IMEM  = 2'd1;
    localparam logic [1:0] SEL_DMEM  = 2'd2;
    localparam logic [1:0] SEL_HAZ   = 2'd3;

    // Readout FSM states
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } rd_state_e;

    // Counters are supported up to this width by sat_max()
    localparam int unsigned CNT_WIDTH_LIMIT = 32;

    // All-ones value of a counter of the given width (the saturation point)
    function automatic logic [31:0] sat_max(input int unsigned width);
        if (width >= CNT_WIDTH_LIMIT) begin
            return 32'hFFFF_FFFF;
        end
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/mesh_perf_mon_node.sv
// Per-node monitor: previous-PC register, saturating stall run length,
// sticky stall flag and saturating imem/dmem/hazard event counters.
// The hazard counter exists only when MESH_PERF_MON_HAZ_EN is defined;
// otherwise haz_cnt_o is tied to zero and haz_i is ignored.
module mesh_perf_mon_node
    import mesh_perf_mon_pkg::*;
#(
    parameter int PC_WIDTH    = 32,
    parameter int CNT_WIDTH   = 16,
    parameter int STALL_LIMIT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable_i,
    input  logic                 clr_i,
    input  logic [PC_WIDTH-1:0]  pc_i,
    input  logic                 imem_busy_i,
    input  logic                 dmem_busy_i,
    input  logic                 haz_i,
    output logic                 stalled_o,
    output logic [CNT_WIDTH-1:0] stall_cnt_o,
    output logic [CNT_WIDTH-1:0] imem_cnt_o,
    output logic [CNT_WIDTH-1:0] dmem_cnt_o,
    output logic [CNT_WIDTH-1:0] haz_cnt_o
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(sat_max(CNT_WIDTH));
    localparam logic [CNT_WIDTH-1:0] LIMIT   = CNT_WIDTH'(STALL_LIMIT);
    localparam logic [CNT_WIDTH-1:0] ONE     = CNT_WIDTH'(1);

    logic [PC_WIDTH-1:0]  prev_pc_q;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic                 stalled_q, stalled_d;
    logic [CNT_WIDTH-1:0] imem_cnt_q, imem_cnt_d;
    logic [CNT_WIDTH-1:0] dmem_cnt_q, dmem_cnt_d;

    // Stall run length and sticky flag; flag sets on the cycle the run hits the limit
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        stalled_d   = stalled_q;
        if (clr_i) begin
            stall_cnt_d = '0;
            stalled_d   = 1'b0;
        end else if (enable_i) begin
            if (pc_i != prev_pc_q) begin
                stall_cnt_d = '0;
            end else if (stall_cnt_q < LIMIT) begin
                stall_cnt_d = stall_cnt_q + ONE;
            end
            if (stall_cnt_d == LIMIT) begin
                stalled_d = 1'b1;
            end
        end
    end

    // Memory busywait event counters, saturating at all-ones
    always_comb begin
        imem_cnt_d = imem_cnt_q;
        dmem_cnt_d = dmem_cnt_q;
        if (clr_i) begin
            imem_cnt_d = '0;
            dmem_cnt_d = '0;
        end else if (enable_i) begin
            if (imem_busy_i && (imem_cnt_q != CNT_MAX)) begin
                imem_cnt_d = imem_cnt_q + ONE;
            end
            if (dmem_busy_i && (dmem_cnt_q != CNT_MAX)) begin
                dmem_cnt_d = dmem_cnt_q + ONE;
            end
        end
    end

    // State registers; prev_pc tracks every cycle so a freeze cannot fake a stall
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_pc_q   <= '0;
            stall_cnt_q <= '0;
            stalled_q   <= 1'b0;
            imem_cnt_q  <= '0;
            dmem_cnt_q  <= '0;
        end else begin
            prev_pc_q   <= pc_i;
            stall_cnt_q <= stall_cnt_d;
            stalled_q   <= stalled_d;
            imem_cnt_q  <= imem_cnt_d;
            dmem_cnt_q  <= dmem_cnt_d;
        end
    end

`ifdef MESH_PERF_MON_HAZ_EN
    logic [CNT_WIDTH-1:0] haz_cnt_q, haz_cnt_d;

    // Load-use hazard event counter, saturating at all-ones
    always_comb begin
        haz_cnt_d = haz_cnt_q;
        if (clr_i) begin
            haz_cnt_d = '0;
        end else if (enable_i && haz_i && (haz_cnt_q != CNT_MAX)) begin
            haz_cnt_d = haz_cnt_q + ONE;
        end
    end

    // Hazard counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            haz_cnt_q <= '0;
        end else begin
            haz_cnt_q <= haz_cnt_d;
        end
    end

    assign haz_cnt_o = haz_cnt_q;
`else
    logic haz_unused;
    assign haz_unused = haz_i;
    assign haz_cnt_o  = '0;
`endif

    assign stalled_o   = stalled_q;
    assign stall_cnt_o = stall_cnt_q;
    assign imem_cnt_o  = imem_cnt_q;
    assign dmem_cnt_o  = dmem_cnt_q;

endmodule

// File: rtl/mesh_perf_monitor.sv
// Mesh activity/stall monitor top: one mesh_perf_mon_node per mesh node,
// sticky stall flags, and a two-state readout port serving counter snapshots.
// Optional hazard counters are built when MESH_PERF_MON_HAZ_EN is defined.
//
// Readout handshake: a request transfers on rd_req_valid & rd_req_ready;
// the response transfers on rd_resp_valid & rd_resp_ready. rd_data is
// captured at request acceptance and held stable until the response transfers.
module mesh_perf_monitor
    import mesh_perf_mon_pkg::*;
#(
    parameter int  ROWS        = 3,
    parameter int  COLS        = 3,
    parameter int  PC_WIDTH    = 32,
    parameter int  CNT_WIDTH   = 16,
    parameter int  STALL_LIMIT = 64,
    localparam int N           = ROWS * COLS,
    localparam int NID_W       = (N > 1) ? $clog2(N) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  clr,
    input  logic [N*PC_WIDTH-1:0] pc_flat,
    input  logic [N-1:0]          imem_busy,
    input  logic [N-1:0]          dmem_busy,
    input  logic [N-1:0]          haz,
    output logic [N-1:0]          stalled,
    output logic                  any_stalled,
    input  logic                  rd_req_valid,
    output logic                  rd_req_ready,
    input  logic [NID_W-1:0]      rd_node,
    input  logic [1:0]            rd_sel,
    output logic                  rd_resp_valid,
    input  logic                  rd_resp_ready,
    output logic [CNT_WIDTH-1:0]  rd_data
);

    logic [CNT_WIDTH-1:0] stall_cnt [N];
    logic [CNT_WIDTH-1:0] imem_cnt  [N];
    logic [CNT_WIDTH-1:0] dmem_cnt  [N];
    logic [CNT_WIDTH-1:0] haz_cnt   [N];

    for (genvar k = 0; k < N; k++) begin : g_node
        mesh_perf_mon_node #(
            .PC_WIDTH    (PC_WIDTH),
            .CNT_WIDTH   (CNT_WIDTH),
            .STALL_LIMIT (STALL_LIMIT)
        ) u_node (
            .clk         (clk),
            .rst         (rst),
            .enable_i    (enable),
            .clr_i       (clr),
            .pc_i        (pc_flat[k*PC_WIDTH +: PC_WIDTH]),
            .imem_busy_i (imem_busy[k]),
            .dmem_busy_i (dmem_busy[k]),
            .haz_i       (haz[k]),
            .stalled_o   (stalled[k]),
            .stall_cnt_o (stall_cnt[k]),
            .imem_cnt_o  (imem_cnt[k]),
            .dmem_cnt_o  (dmem_cnt[k]),
            .haz_cnt_o   (haz_cnt[k])
        );
    end

    assign any_stalled = |stalled;

    logic                 node_ok;
    logic [CNT_WIDTH-1:0] sel_data;
    rd_state_e            state_q;
    logic                 req_ready_q;
    logic                 resp_valid_q;
    logic [CNT_WIDTH-1:0] rd_data_q;

    assign node_ok = (32'(rd_node) < N);

    // Counter selection; out-of-range node indices read as zero
    always_comb begin
        sel_data = '0;
        if (node_ok) begin
            case (rd_sel)
                SEL_STALL: sel_data = stall_cnt[rd_node];
                SEL_IMEM:  sel_data = imem_cnt[rd_node];
                SEL_DMEM:  sel_data = dmem_cnt[rd_node];
                SEL_HAZ:   sel_data = haz_cnt[rd_node];
                default:   sel_data = '0;
            endcase
        end
    end

    // Readout FSM; snapshot is the registered counter value at the accept edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            rd_data_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (rd_req_valid) begin
                        state_q      <= ST_RESP;
                        req_ready_q  <= 1'b0;
                        resp_valid_q <= 1'b1;
                        rd_data_q    <= sel_data;
                    end
                end
                ST_RESP: begin
                    if (rd_resp_ready) begin
                        state_q      <= ST_IDLE;
                        req_ready_q  <= 1'b1;
                        resp_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= ST_IDLE;
                    req_ready_q  <= 1'b1;
                    resp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign rd_req_ready  = req_ready_q;
    assign rd_resp_valid = resp_valid_q;
    assign rd_data       = rd_data_q;

endmodule

// File: tb/tb_mesh_perf_monitor.sv
// Self-checking bench for mesh_perf_monitor: directed vectors, a behavioural
// model of per-node activity, and a per-cycle compare against the outputs.
module tb_mesh_perf_monitor;

    localparam int ROWS  = 3;
    localparam int COLS  = 3;
    localparam int N     = ROWS * COLS;
    localparam int NID_W = 4;
    localparam int PW    = 16;
    localparam int CW    = 7;
    localparam int LIMIT = 64;
    localparam int CMAX  = (1 << CW) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              enable;
    logic              clr;
    logic [N*PW-1:0]   pc_flat;
    logic [N-1:0]      imem_busy;
    logic [N-1:0]      dmem_busy;
    logic [N-1:0]      haz;
    logic [N-1:0]      stalled;
    logic              any_stalled;
    logic              rd_req_valid;
    logic              rd_req_ready;
    logic [NID_W-1:0]  rd_node;
    logic [1:0]        rd_sel;
    logic              rd_resp_valid;
    logic              rd_resp_ready;
    logic [CW-1:0]     rd_data;

    logic [PW-1:0]     pc_v [N];
    logic [N-1:0]      hold;

    int total = 0;
    int bad   = 0;

    mesh_perf_monitor #(
        .ROWS        (ROWS),
        .COLS        (COLS),
        .PC_WIDTH    (PW),
        .CNT_WIDTH   (CW),
        .STALL_LIMIT (LIMIT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .clr           (clr),
        .pc_flat       (pc_flat),
        .imem_busy     (imem_busy),
        .dmem_busy     (dmem_busy),
        .haz           (haz),
        .stalled       (stalled),
        .any_stalled   (any_stalled),
        .rd_req_valid  (rd_req_valid),
        .rd_req_ready  (rd_req_ready),
        .rd_node       (rd_node),
        .rd_sel        (rd_sel),
        .rd_resp_valid (rd_resp_valid),
        .rd_resp_ready (rd_resp_ready),
        .rd_data       (rd_data)
    );

    // clock
    always #5 clk = ~clk;

    always_comb begin
        for (int k = 0; k < N; k++) pc_flat[k*PW +: PW] = pc_v[k];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Unbounded run lengths and event totals; saturation applied when read.
    int            m_run  [N];
    int            m_imem [N];
    int            m_dmem [N];
    int            m_haz  [N];
    logic [PW-1:0] m_prev [N];
    logic [N-1:0]  m_stk;
    logic [CW-1:0] exp_q [$];
    logic [CW-1:0] m_last;

    function automatic int clip(input int v, input int hi);
        return (v > hi) ? hi : v;
    endfunction

    function automatic logic [CW-1:0] snap(input int node, input int sel);
        int v;
        v = 0;
        if (node < N) begin
            case (sel)
                0: v = clip(m_run[node], LIMIT);
                1: v = clip(m_imem[node], CMAX);
                2: v = clip(m_dmem[node], CMAX);
`ifdef MESH_PERF_MON_HAZ_EN
                3: v = clip(m_haz[node], CMAX);
`endif
                default: v = 0;
            endcase
        end
        return CW'(v);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N; k++) begin
                m_run[k] = 0; m_imem[k] = 0; m_dmem[k] = 0; m_haz[k] = 0; m_prev[k] = '0;
            end
            m_stk  = '0;
            m_last = '0;
            exp_q.delete();
        end else begin
            if (exp_q.size() != 0) begin
                if (rd_resp_ready) m_last = exp_q.pop_front();
            end else if (rd_req_valid) begin
                exp_q.push_back(snap(int'(rd_node), int'(rd_sel)));
            end
            for (int k = 0; k < N; k++) begin
                if (clr) begin
                    m_run[k] = 0; m_imem[k] = 0; m_dmem[k] = 0; m_haz[k] = 0; m_stk[k] = 1'b0;
                end else if (enable) begin
                    m_run[k] = (pc_v[k] == m_prev[k]) ? m_run[k] + 1 : 0;
                    if (m_run[k] >= LIMIT) m_stk[k] = 1'b1;
                    if (imem_busy[k]) m_imem[k]++;
                    if (dmem_busy[k]) m_dmem[k]++;
                    if (haz[k])       m_haz[k]++;
                end
                m_prev[k] = pc_v[k];
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        logic          pend;
        logic [CW-1:0] exp_data;
        pend     = (exp_q.size() != 0);
        exp_data = pend ? exp_q[0] : m_last;
        check("cyc_stalled", 32'(stalled), 32'(m_stk));
        check("cyc_any_stalled", 32'(any_stalled), 32'(|m_stk));
        check("cyc_req_ready", 32'(rd_req_ready), 32'(!pend));
        check("cyc_resp_valid", 32'(rd_resp_valid), 32'(pend));
        check("cyc_rd_data", 32'(rd_data), 32'(exp_data));
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) begin
            if (!hold[k]) pc_v[k] = pc_v[k] + PW'(1);
        end
    endtask

    task automatic do_read(input int node, input int sel, output logic [CW-1:0] data);
        int waited;
        waited        = 0;
        rd_node       = NID_W'(node);
        rd_sel        = 2'(sel);
        rd_resp_ready = 1'b1;
        while (!rd_req_ready && waited < 20) begin
            tick();
            waited++;
        end
        check("read_req_ready_wait", 32'(rd_req_ready), 32'd1);
        rd_req_valid = 1'b1;
        tick();
        rd_req_valid = 1'b0;
        check("read_resp_valid", 32'(rd_resp_valid), 32'd1);
        data = rd_data;
        tick();
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        logic [CW-1:0] d;
        rst = 1'b1; enable = 1'b0; clr = 1'b0;
        imem_busy = '0; dmem_busy = '0; haz = '0; hold = '0;
        rd_req_valid = 1'b0; rd_resp_ready = 1'b1; rd_node = '0; rd_sel = '0;
        for (int k = 0; k < N; k++) pc_v[k] = PW'(k * 256 + 1);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // reset state
        check("rst_stalled", 32'(stalled), 32'd0);
        check("rst_any_stalled", 32'(any_stalled), 32'd0);
        check("rst_req_ready", 32'(rd_req_ready), 32'd1);
        check("rst_resp_valid", 32'(rd_resp_valid), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);

        // all PCs moving: nothing stalls
        enable = 1'b1;
        repeat (200) tick();
        check("moving_stalled", 32'(stalled), 32'd0);
        for (int k = 0; k < N; k++) begin
            do_read(k, 0, d);
            check("moving_stall_run", 32'(d), 32'd0);
        end

        // node 4 held: flag rises after exactly LIMIT matching cycles
        tick();
        pc_v[4] = 16'h0040;
        hold[4] = 1'b1;
        repeat (LIMIT) tick();
        check("stall_before_limit", 32'(stalled[4]), 32'd0);
        tick();
        check("stall_at_limit", 32'(stalled[4]), 32'd1);
        check("stall_any", 32'(any_stalled), 32'd1);
        do_read(4, 0, d);
        check("stall_run_saturated", 32'(d), 32'(LIMIT));
        hold[4] = 1'b0;
        repeat (5) tick();
        check("stall_sticky", 32'(stalled), 32'h10);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("stall_clr", 32'(stalled), 32'd0);
        check("stall_clr_any", 32'(any_stalled), 32'd0);

        // dmem busy on node 0 for 37 cycles
        dmem_busy[0] = 1'b1;
        repeat (37) tick();
        dmem_busy[0] = 1'b0;
        do_read(0, 2, d);
        check("dmem_count_37", 32'(d), 32'd37);
        do_read(0, 1, d);
        check("imem_count_0", 32'(d), 32'd0);

        // imem busy on node 8 long enough to saturate
        imem_busy[8] = 1'b1;
        repeat (140) tick();
        imem_busy[8] = 1'b0;
        do_read(8, 1, d);
        check("imem_saturate", 32'(d), 32'(CMAX));
        do_read(9, 1, d);
        check("oob_node9", 32'(d), 32'd0);
        do_read(15, 2, d);
        check("oob_node15", 32'(d), 32'd0);

        // freeze: no counting, no fake stall on resume
        enable = 1'b0;
        dmem_busy[0] = 1'b1;
        hold[4] = 1'b1;
        repeat (70) tick();
        hold[4] = 1'b0;
        dmem_busy[0] = 1'b0;
        enable = 1'b1;
        repeat (3) tick();
        check("freeze_no_stall", 32'(stalled), 32'd0);
        do_read(0, 2, d);
        check("freeze_dmem_held", 32'(d), 32'd37);

        // response back-pressure
        rd_node = 4'd0; rd_sel = 2'd2; rd_resp_ready = 1'b0; rd_req_valid = 1'b1;
        tick();
        rd_node = 4'd5;
        for (int i = 0; i < 5; i++) begin
            check("bp_req_ready", 32'(rd_req_ready), 32'd0);
            check("bp_resp_valid", 32'(rd_resp_valid), 32'd1);
            check("bp_data_stable", 32'(rd_data), 32'd37);
            tick();
        end
        rd_resp_ready = 1'b1;
        tick();
        check("bp_after_hs_ready", 32'(rd_req_ready), 32'd1);
        check("bp_after_hs_valid", 32'(rd_resp_valid), 32'd0);
        tick();
        rd_req_valid = 1'b0;
        check("bp_second_valid", 32'(rd_resp_valid), 32'd1);
        check("bp_second_data", 32'(rd_data), 32'd0);
        tick();

        // clr beats a same-cycle hazard strobe
        clr = 1'b1;
        haz[2] = 1'b1;
        tick();
        clr = 1'b0;
        haz[2] = 1'b0;
        tick();
        do_read(2, 3, d);
        check("haz_clr_priority", 32'(d), 32'd0);
        do_read(0, 2, d);
        check("clr_dmem", 32'(d), 32'd0);
        haz[2] = 1'b1;
        repeat (3) tick();
        haz[2] = 1'b0;
        do_read(2, 3, d);
`ifdef MESH_PERF_MON_HAZ_EN
        check("haz_count", 32'(d), 32'd3);
`else
        check("haz_disabled", 32'(d), 32'd0);
`endif

        // reset while a response is pending
        dmem_busy[1] = 1'b1;
        repeat (4) tick();
        dmem_busy[1] = 1'b0;
        rd_node = 4'd1; rd_sel = 2'd2; rd_resp_ready = 1'b0; rd_req_valid = 1'b1;
        tick();
        rd_req_valid = 1'b0;
        check("mid_rst_pending", 32'(rd_resp_valid), 32'd1);
        check("mid_rst_data", 32'(rd_data), 32'd4);
        rst = 1'b1;
        #1;
        check("mid_rst_valid_drop", 32'(rd_resp_valid), 32'd0);
        check("mid_rst_ready", 32'(rd_req_ready), 32'd1);
        check("mid_rst_data_zero", 32'(rd_data), 32'd0);
        tick();
        rst = 1'b0;
        rd_resp_ready = 1'b1;
        repeat (2) tick();
        do_read(1, 2, d);
        check("post_rst_dmem", 32'(d), 32'd0);

        repeat (2) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
